// File: rtl/mips_pkg.sv
// Shared types and constants for the pipelined core's fetch path.
package mips_pkg;

  typedef enum logic {IDLE, REFILL} icache_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/icache_data_ram.sv
// Instruction cache data array: synchronous write, asynchronous read.
module icache_data_ram #(
  parameter  int unsigned LINES = 16,
  parameter  int unsigned WORDS = 4,
  localparam int unsigned IDX_W = $clog2(LINES),
  localparam int unsigned OFF_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  logic [OFF_W-1:0] woff_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] ridx_i,
  input  logic [OFF_W-1:0] roff_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [LINES][WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[widx_i][woff_i] <= wdata_i;
  end

  assign rdata_o = mem_q[ridx_i][roff_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with in-order whole-line refill.
module icache
  import mips_pkg::*;
#(
  parameter  int unsigned LINES = 16,
  parameter  int unsigned WORDS = 4,
  localparam int unsigned IDX_W = $clog2(LINES),
  localparam int unsigned OFF_W = $clog2(WORDS),
  localparam int unsigned TAG_W = 32 - IDX_W - OFF_W - 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcF,
  output logic [31:0] instrF,
  output logic        icache_stall,
  input  logic        inv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  icache_state_t    state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [TAG_W-1:0] rtag_q, rtag_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic             inv_seen_q, inv_seen_d;
  logic             fill_done;
  logic             hit;
  logic [31:0]      rdata;
  logic             unused_pc;

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;

  assign pc_off    = pcF[OFF_W+1:2];
  assign pc_idx    = pcF[OFF_W+IDX_W+1:OFF_W+2];
  assign pc_tag    = pcF[31:OFF_W+IDX_W+2];
  assign unused_pc = ^pcF[1:0];

  assign hit = (state_q == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  icache_data_ram #(.LINES(LINES), .WORDS(WORDS)) u_data (
    .clk     (clk),
    .we_i    ((state_q == REFILL) && mem_ack),
    .widx_i  (ridx_q),
    .woff_i  (cnt_q),
    .wdata_i (mem_rdata),
    .ridx_i  (pc_idx),
    .roff_i  (pc_off),
    .rdata_o (rdata)
  );

  // Next-state: miss capture, beat counting, line install and invalidation.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    rtag_d     = rtag_q;
    ridx_d     = ridx_q;
    cnt_d      = cnt_q;
    inv_seen_d = inv_seen_q | inv;
    fill_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!hit) begin
          state_d    = REFILL;
          rtag_d     = pc_tag;
          ridx_d     = pc_idx;
          cnt_d      = '0;
          inv_seen_d = 1'b0;
        end
      end
      REFILL: begin
        if (mem_ack) begin
          cnt_d = cnt_q + OFF_W'(1);
          if (cnt_q == OFF_W'(WORDS - 1)) begin
            state_d         = IDLE;
            fill_done       = 1'b1;
            valid_d[ridx_q] = ~inv_seen_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // An invalidate on the install edge also wins over the new line.
    if (inv) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      rtag_q     <= '0;
      ridx_q     <= '0;
      cnt_q      <= '0;
      inv_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      rtag_q     <= rtag_d;
      ridx_q     <= ridx_d;
      cnt_q      <= cnt_d;
      inv_seen_q <= inv_seen_d;
    end
  end

  // Tags need no reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (!reset && fill_done) tag_q[ridx_q] <= rtag_q;
  end

  assign icache_stall = ~hit;
  assign instrF       = hit ? rdata : NOP_INSTR;
  assign mem_req      = (state_q == REFILL);
  assign mem_addr     = (state_q == REFILL) ? {rtag_q, ridx_q, cnt_q, 2'b00} : 32'h0;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: line-level reference model plus literal pins.
module tb_icache;

  localparam int unsigned LINES = 16;
  localparam int unsigned WORDS = 4;
  localparam int unsigned OFF   = $clog2(WORDS);

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic        icache_stall;
  logic        inv;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int waits  = 0;
  int wcnt   = 0;

  always #5 clk = ~clk;

  icache #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk          (clk),
    .reset        (reset),
    .pcF          (pcF),
    .instrF       (instrF),
    .icache_stall (icache_stall),
    .inv          (inv),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign mem_rdata = mem_ack ? mem_fn(mem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: resident line base addresses and a queue of pending beats.
  bit          m_started = 1'b0;
  bit          m_valid [LINES];
  logic [31:0] m_base  [LINES];
  bit          m_busy = 1'b0;
  bit          m_inv_seen = 1'b0;
  int          m_fidx = 0;
  logic [31:0] m_fbase = '0;
  logic [31:0] m_q [$];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> (OFF + 2)) % LINES);
  endfunction

  function automatic logic [31:0] base_of(input logic [31:0] a);
    return a & ~32'(WORDS * 4 - 1);
  endfunction

  always begin
    bit exp_hit;
    @(negedge clk);
    #2;
    exp_hit = !m_busy && m_valid[idx_of(pcF)] && (m_base[idx_of(pcF)] == base_of(pcF));
    if (m_started) begin
      chk("stall",    32'(icache_stall), 32'(!exp_hit));
      chk("instrF",   instrF, exp_hit ? mem_fn({pcF[31:2], 2'b00}) : 32'h0);
      chk("mem_req",  32'(mem_req), 32'(m_busy));
      chk("mem_addr", mem_addr, m_busy ? m_q[0] : 32'h0);
    end
    if (reset) begin
      m_started = 1'b1;
      m_busy    = 1'b0;
      m_q.delete();
      for (int i = 0; i < int'(LINES); i++) m_valid[i] = 1'b0;
    end else if (m_started) begin
      if (m_busy) begin
        if (inv) m_inv_seen = 1'b1;
        if (mem_ack) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_busy           = 1'b0;
            m_valid[m_fidx]  = !m_inv_seen;
            m_base[m_fidx]   = m_fbase;
          end
        end
      end else if (!exp_hit) begin
        m_busy     = 1'b1;
        m_inv_seen = 1'b0;
        m_fidx     = idx_of(pcF);
        m_fbase    = base_of(pcF);
        for (int k = 0; k < int'(WORDS); k++) m_q.push_back(m_fbase + 32'(4 * k));
      end
      if (inv) for (int i = 0; i < int'(LINES); i++) m_valid[i] = 1'b0;
    end
  end

  // One cycle of stimulus; the memory responder acks after `waits` idle cycles.
  task automatic tick(input logic [31:0] pc, input logic iv, input logic rst);
    @(negedge clk);
    pcF   = pc;
    inv   = iv;
    reset = rst;
    if (mem_req) begin
      if (wcnt == waits) begin
        mem_ack = 1'b1;
        wcnt    = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  endtask

  logic [31:0] acked [$];

  // Holds pc until it hits; returns the number of stall cycles observed.
  task automatic run_until_hit(input logic [31:0] pc, output int n);
    n = 0;
    acked.delete();
    for (int c = 0; c < 60; c++) begin
      tick(pc, 1'b0, 1'b0);
      #3;
      if (mem_ack) acked.push_back(mem_addr);
      if (!icache_stall) return;
      n++;
    end
    chk("hit_timeout", 32'(n), 32'hFFFF_FFFF);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    reset   = 1'b1;
    pcF     = 32'h0;
    inv     = 1'b0;
    mem_ack = 1'b0;
    tick(32'h40, 1'b0, 1'b1);
    tick(32'h40, 1'b0, 1'b1);
    #3;
    chk("reset_stall", 32'(icache_stall), 32'h1);
    chk("reset_req",   32'(mem_req), 32'h0);
    chk("reset_addr",  mem_addr, 32'h0);

    // Cold start, zero-wait memory.
    run_until_hit(32'h40, n);
    chk("cold_stall_cycles", 32'(n), 32'd5);
    chk("cold_beats", 32'(acked.size()), 32'd4);
    for (int k = 0; k < 4 && k < acked.size(); k++) begin
      a = acked[k];
      chk("cold_addr", a, 32'h40 + 32'(4 * k));
    end
    chk("cold_instr", instrF, 32'hC0DE_0040);

    // Same-line hits.
    for (int k = 1; k < 4; k++) begin
      tick(32'h40 + 32'(4 * k), 1'b0, 1'b0);
      #3;
      chk("hit_instr", instrF, 32'hC0DE_0040 + 32'(4 * k));
      chk("hit_stall", 32'(icache_stall), 32'h0);
      chk("hit_req",   32'(mem_req), 32'h0);
    end

    // Conflict miss evicts 0x40.
    run_until_hit(32'h140, n);
    chk("conf_stall_cycles", 32'(n), 32'd5);
    a = (acked.size() > 0) ? acked[0] : 32'hFFFF_FFFF;
    chk("conf_first_addr", a, 32'h140);
    chk("conf_instr", instrF, 32'hC0DE_0140);
    tick(32'h40, 1'b0, 1'b0);
    #3;
    chk("conf_remiss", 32'(icache_stall), 32'h1);
    run_until_hit(32'h40, n);

    // Two wait states per beat.
    waits = 2;
    run_until_hit(32'h208, n);
    chk("wait_stall_cycles", 32'(n), 32'd13);
    chk("wait_instr", instrF, 32'hC0DE_0208);
    waits = 0;

    // inv during beat 2: line ends invalid, other lines too.
    run_until_hit(32'h80, n);
    tick(32'h300, 1'b0, 1'b0);
    tick(32'h300, 1'b0, 1'b0);
    tick(32'h300, 1'b1, 1'b0);
    tick(32'h300, 1'b0, 1'b0);
    tick(32'h300, 1'b0, 1'b0);
    tick(32'h300, 1'b0, 1'b0);
    #3;
    chk("inv_refill_remiss", 32'(icache_stall), 32'h1);
    run_until_hit(32'h300, n);
    chk("inv_refill_again", 32'(n), 32'd4);
    tick(32'h80, 1'b0, 1'b0);
    #3;
    chk("inv_other_line", 32'(icache_stall), 32'h1);

    // inv coinciding with the final ack.
    run_until_hit(32'h80, n);
    tick(32'h90, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick(32'h90, 1'b0, 1'b0);
    tick(32'h90, 1'b1, 1'b0);
    tick(32'h90, 1'b0, 1'b0);
    #3;
    chk("inv_last_ack", 32'(icache_stall), 32'h1);
    run_until_hit(32'h90, n);

    // inv with a hit in IDLE still hits that cycle.
    tick(32'h94, 1'b1, 1'b0);
    #3;
    chk("inv_hit_same", instrF, 32'hC0DE_0094);
    tick(32'h94, 1'b0, 1'b0);
    #3;
    chk("inv_hit_next", 32'(icache_stall), 32'h1);
    run_until_hit(32'h94, n);

    // Reset after beat 1 abandons the refill.
    tick(32'h400, 1'b0, 1'b0);
    tick(32'h400, 1'b0, 1'b0);
    tick(32'h400, 1'b0, 1'b1);
    tick(32'h400, 1'b0, 1'b0);
    #3;
    chk("rst_mid_req", 32'(mem_req), 32'h0);
    tick(32'h400, 1'b0, 1'b0);
    #3;
    chk("rst_mid_word0", mem_addr, 32'h400);
    run_until_hit(32'h40C, n);
    chk("rst_mid_instr", instrF, 32'hC0DE_040C);

    tick(32'h40C, 1'b0, 1'b0);
    @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache answering the pipelined core's fetch port. The core drives `pcF` and expects `instrF` back in the same cycle. On a hit the word is returned combinationally. On a miss the cache asserts `icache_stall` into the hazard unit, refills the whole line from backing memory one word per handshake, then releases the stall.

## Interface
Parameters:
- `LINES`, 16: number of lines; power of 2, ≥ 2.
- `WORDS`, 4: 32-bit words per line; power of 2, ≥ 2.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `pcF`  in  32  fetch byte address; bits [1:0] ignored.
- `instrF`  out  32  fetched instruction; 32'h0 when not a hit.
- `icache_stall`  out  1  high while `instrF` is not valid for `pcF`.
- `inv`  in  1  one-cycle pulse; invalidate all lines.
- `mem_req`  out  1  backing-memory read request.
- `mem_addr`  out  32  word-aligned read address.
- `mem_ack`  in  1  memory accepts the request and returns data this cycle.
- `mem_rdata`  in  32  read data, valid when `mem_ack` is high.

## Operation
- Address split: `OFF = log2(WORDS)`, `IDX = log2(LINES)`.
  - Word offset = `pcF[OFF+1:2]`.
  - Index = `pcF[OFF+IDX+1:OFF+2]`.
  - Tag = `pcF[31:OFF+IDX+2]`.
- Per-line storage: valid bit, tag, `WORDS` data words.
- `hit` = (state == IDLE) & valid[index] & (tag[index] == pcF tag). Purely combinational.
- `icache_stall` = ~hit. `instrF` = hit ? data[index][offset] : 32'h0.
- FSM states: IDLE, REFILL.
  - IDLE → REFILL on a miss. At that edge: latch tag and index, clear the word counter, clear `inv_seen`.
  - REFILL: `mem_req` = 1 and `mem_addr` = {latched tag, latched index, counter, 2'b00}.
    - Each cycle with `mem_ack` high: write `mem_rdata` into data[idx][counter], then increment the counter.
  - REFILL → IDLE at the edge where `mem_ack` is high and the counter = WORDS-1. At that edge: set tag[idx] and valid[idx] = ~`inv_seen`.
  - No other transitions; a refill is never aborted except by reset.
- `mem_addr` and `mem_req` stay stable until acked. Only `mem_ack` advances the counter; wait states of any length are legal.
- `inv`:
  - Clears every valid bit at the next edge, in either state.
  - During REFILL it also sets `inv_seen`, so the line being filled is left invalid.
- If `pcF` changes during REFILL (branch redirect while stalled), the refill still completes for the latched address. On return to IDLE, the new `pcF` is looked up normally.
- Sequential fill order: word 0 first. No critical-word-first.

## Timing
- Reset (synchronous) brings all state to reset values at the edge:
  - state = IDLE, all valid = 0, counter = 0, `inv_seen` = 0.
  - Outputs: `mem_req` = 0, `mem_addr` = 0, `icache_stall` = 1, `instrF` = 0.
- Reset mid-refill: the request drops at that edge and no line is marked valid. Memory must tolerate an abandoned request.
- Hit latency: 0 cycles, combinational from `pcF`.
- Miss penalty with zero-wait memory (ack every REFILL cycle): stall high for 1 + WORDS cycles.
  - 1 cycle for the miss-detect cycle, then WORDS beats.
  - Hit in the cycle after the last ack.
- Each memory wait state adds exactly one stall cycle.
- Simultaneous `inv` and final ack: the line ends invalid, and the cache re-misses in the next cycle.
- Simultaneous `inv` and a hit in IDLE: that cycle still hits (valid bits are cleared at the edge).
- Index wrap: the counter wraps only via the REFILL → IDLE transition, never within a line.

## Structure
- Shared package `mips_pkg` holds:
  - `typedef enum logic {IDLE, REFILL} icache_state_t`.
  - `localparam logic [31:0] NOP_INSTR = 32'h0`.
- Sub-module `icache_data_ram`:
  - `LINES`×`WORDS`×32 storage.
  - Synchronous write port: index, offset, data, we.
  - Asynchronous read port: index, offset.
- Tag/valid arrays and the FSM live in `icache`.

## Test plan
- Cold start: reset, `pcF`=0x0000_0040. Expect stall high for 5 cycles (zero-wait memory) with `mem_addr` 0x40, 0x44, 0x48, 0x4C. Then `instrF` = mem[0x40] and stall low.
- Same-line hits: after the fill, `pcF`=0x44, 0x48, 0x4C on consecutive cycles. Each returns its word with stall low and `mem_req` low.
- Conflict miss: `pcF`=0x0000_0140 (same index, tag differs). Expect a refill from 0x140, then 0x40 misses again.
- Wait states: `mem_ack` low 2 cycles per beat on a miss. Expect stall for 1+4×3 = 13 cycles, with `mem_addr` stable during waits.
- `inv` during REFILL (beat 2): the line completes, but the next cycle misses and refills again. A hit line elsewhere is also invalid afterwards.
- Reset mid-refill after beat 1: `mem_req` = 0 at the next edge, and a re-fetch of the same `pcF` starts from word 0.
